// File: rtl/rvcpu_pkg.sv
// Shared CPU definitions: default widths, fetch state encoding and the
// {pc, inst} entry layout used by the instruction fetch queue.
package rvcpu_pkg;

  localparam int              WORD_LEN_DEFAULT = 32;
  localparam logic [31:0]     RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch control state: S_RESET lasts one cycle after reset, S_FETCH is terminal.
  typedef enum logic {
    S_RESET = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_e;

  // One queue entry: instruction and the pc it was fetched from.
  typedef struct packed {
    logic [WORD_LEN_DEFAULT-1:0] pc;
    logic [WORD_LEN_DEFAULT-1:0] inst;
  } ifq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_sync_fifo.sv
// sync_fifo: DEPTH-entry synchronous FIFO with push/pop/flush and occupancy.
// Pointers carry one extra bit so full and empty are distinguishable; the
// head is read straight from registered storage.
module sync_fifo #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 4,
  parameter int DEPTH_BIT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [WIDTH-1:0]     i_push_data,
  input  logic                 i_pop,
  input  logic                 i_flush,
  output logic [WIDTH-1:0]     o_head,
  output logic [DEPTH_BIT:0]   o_count,
  output logic                 o_empty
);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [DEPTH_BIT:0] r_wr_ptr;
  logic [DEPTH_BIT:0] r_rd_ptr;
  logic               w_full;
  logic               w_do_pop;
  logic               w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[DEPTH_BIT] != r_rd_ptr[DEPTH_BIT]) &&
                     (r_wr_ptr[DEPTH_BIT-1:0] == r_rd_ptr[DEPTH_BIT-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  // A pop on a full queue frees the slot the simultaneous push writes into.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[DEPTH_BIT-1:0]];

  // Pointer update; flush empties the queue and overrides push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{DEPTH_BIT{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{DEPTH_BIT{1'b0}}, 1'b1};
    end
  end

  // Entry storage, cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr[DEPTH_BIT-1:0]] <= i_push_data;
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential instruction fetch with credit-limited requests,
// an in-order response queue toward decode and redirect handling that drops
// responses still in flight from the old path.
// Optional feature macro: IFQ_BYPASS_EN (zero-latency response-to-decode path
// when the queue is empty).
module inst_fetch_queue
  import rvcpu_pkg::*;
#(
  parameter int                     WORD_LEN  = WORD_LEN_DEFAULT,
  parameter logic [WORD_LEN-1:0]    RESET_PC  = RESET_PC_DEFAULT[WORD_LEN-1:0],
  parameter int                     DEPTH     = 4,
  parameter int                     DEPTH_BIT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [WORD_LEN-1:0]  imem_req_addr,
  input  logic                 imem_resp_valid,
  input  logic [WORD_LEN-1:0]  imem_resp_inst,
  input  logic                 redirect_valid,
  input  logic [WORD_LEN-1:0]  redirect_pc,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [WORD_LEN-1:0]  id_pc,
  output logic [WORD_LEN-1:0]  id_inst
);

  fetch_state_e          r_state;
  logic [WORD_LEN-1:0]   r_fetch_pc;
  logic [WORD_LEN-1:0]   r_resp_pc;
  logic [DEPTH_BIT:0]    r_outstanding;
  logic [DEPTH_BIT:0]    r_drop_cnt;

  logic [DEPTH_BIT:0]    w_count;
  logic                  w_empty;
  logic [2*WORD_LEN-1:0] w_head;
  logic [DEPTH_BIT+1:0]  w_credit_used;
  logic                  w_req_fire;
  logic                  w_resp_drop;
  logic                  w_resp_keep;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic [DEPTH_BIT:0]    w_outstanding_next;
  logic [WORD_LEN-1:0]   w_redir_pc;
  logic                  w_unused_redir_lsb;

  localparam logic [WORD_LEN-1:0] PC_STEP = WORD_LEN'(3'd4);

  // Credit: every outstanding request owns a queue slot, so the queue never overflows.
  assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, w_count};
  assign imem_req_valid = (r_state == S_FETCH) && (w_credit_used < (DEPTH_BIT+2)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_redir_pc         = {redirect_pc[WORD_LEN-1:2], 2'b00};
  assign w_unused_redir_lsb = ^redirect_pc[1:0];

  assign w_resp_drop = imem_resp_valid && (r_drop_cnt != '0);
  // A response arriving with a redirect belongs to the old path and is discarded.
  assign w_resp_keep = imem_resp_valid && (r_drop_cnt == '0) && !redirect_valid;

  assign w_outstanding_next = r_outstanding + {{DEPTH_BIT{1'b0}}, w_req_fire}
                                            - {{DEPTH_BIT{1'b0}}, imem_resp_valid};

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_empty && w_resp_keep;
  assign id_valid = !w_empty || w_bypass;
  assign id_pc    = w_bypass ? r_resp_pc      : w_head[2*WORD_LEN-1:WORD_LEN];
  assign id_inst  = w_bypass ? imem_resp_inst : w_head[WORD_LEN-1:0];
`else
  assign w_bypass = 1'b0;
  assign id_valid = !w_empty;
  assign id_pc    = w_head[2*WORD_LEN-1:WORD_LEN];
  assign id_inst  = w_head[WORD_LEN-1:0];
`endif

  // A bypassed response consumed by decode this cycle is never stored.
  assign w_push = w_resp_keep && !(w_bypass && id_ready);
  assign w_pop  = !w_empty && id_ready && !redirect_valid;

  sync_fifo #(
    .WIDTH     (2*WORD_LEN),
    .DEPTH     (DEPTH),
    .DEPTH_BIT (DEPTH_BIT)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data ({r_resp_pc, imem_resp_inst}),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_empty     (w_empty)
  );

  // Fetch FSM, pc registers, outstanding/drop counters and redirect handling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RESET;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      case (r_state)
        S_RESET: r_state <= S_FETCH;
        S_FETCH: r_state <= S_FETCH;
        default: r_state <= S_RESET;
      endcase
      r_outstanding <= w_outstanding_next;
      if (redirect_valid) begin
        r_fetch_pc <= w_redir_pc;
        r_resp_pc  <= w_redir_pc;
        // Everything left in flight after this cycle is old-path; pending drops
        // are already part of that total, so they are not added a second time.
        r_drop_cnt <= w_outstanding_next;
      end else begin
        if (w_req_fire)  r_fetch_pc <= r_fetch_pc + PC_STEP;
        if (w_resp_keep) r_resp_pc  <= r_resp_pc + PC_STEP;
        if (w_resp_drop) r_drop_cnt <= r_drop_cnt - {{DEPTH_BIT{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: behavioural memory with random in-order latency,
// an epoch-tagged reference model of the decode stream, and directed phases.
module tb_inst_fetch_queue;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .WORD_LEN (32), .RESET_PC (32'h0), .DEPTH (D), .DEPTH_BIT (2)
  ) dut (
    .clk (clk), .rst (rst),
    .imem_req_valid (imem_req_valid), .imem_req_ready (imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_resp_valid (imem_resp_valid), .imem_resp_inst (imem_resp_inst),
    .redirect_valid (redirect_valid), .redirect_pc (redirect_pc),
    .id_valid (id_valid), .id_ready (id_ready),
    .id_pc (id_pc), .id_inst (id_inst)
  );

  typedef struct { logic [31:0] addr; int epoch; int rdy; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  req_t        mem_q[$];      // requests accepted by memory, in order
  ent_t        mq[$];         // expected decode queue contents
  logic [31:0] deq_log[$];
  logic [31:0] req_log[$];
  int          cyc, epoch, last_rdy;
  logic [31:0] m_fetch_pc;
  bit          m_started;
  int          total, bad;
  int          k_ready, k_idready, k_redir, k_latmin, k_latmax;
  bit          force_redir;
  logic [31:0] force_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step();
    bit          fire, deq, resp, redir, byp, exp_req_v, exp_id_v;
    logic [31:0] rpc;
    req_t        r;
    ent_t        head, dummy;
    int          lat, rdy;
    @(negedge clk);
    imem_req_ready = ($urandom_range(99) < k_ready);
    id_ready       = ($urandom_range(99) < k_idready);
    redir          = force_redir || ($urandom_range(999) < k_redir);
    rpc            = force_redir ? force_pc : $urandom;
    force_redir    = 1'b0;
    redirect_valid = redir;
    redirect_pc    = rpc;
    resp           = (mem_q.size() != 0) && (mem_q[0].rdy <= cyc);
    if (resp) r = mem_q[0];
    imem_resp_valid = resp;
    imem_resp_inst  = resp ? inst_of(r.addr) : $urandom;
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = (mq.size() == 0) && resp && (r.epoch == epoch) && !redir;
`endif
    #1;
    exp_req_v = m_started && ((mem_q.size() + mq.size()) < D);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req_v});
    if (exp_req_v) chk("req_addr", imem_req_addr, m_fetch_pc);
    exp_id_v = (mq.size() != 0) || byp;
    chk("id_valid", {31'b0, id_valid}, {31'b0, exp_id_v});
    if (exp_id_v) begin
      if (mq.size() != 0) head = mq[0];
      else begin head.pc = r.addr; head.inst = inst_of(r.addr); end
      chk("id_pc", id_pc, head.pc);
      chk("id_inst", id_inst, head.inst);
    end
    fire = imem_req_valid && imem_req_ready;
    deq  = exp_id_v && id_ready;
    if (deq && !redir) deq_log.push_back(id_pc);
    @(posedge clk);
    cyc++;
    if (resp) void'(mem_q.pop_front());
    if (redir) mq.delete();
    else begin
      if (deq && mq.size() != 0) dummy = mq.pop_front();
      if (resp && r.epoch == epoch && !(byp && id_ready)) begin
        head.pc = r.addr; head.inst = inst_of(r.addr);
        mq.push_back(head);
      end
    end
    if (fire) begin
      lat = $urandom_range(k_latmax, k_latmin);
      rdy = cyc - 1 + lat;
      if (rdy <= last_rdy) rdy = last_rdy + 1;
      last_rdy = rdy;
      mem_q.push_back('{addr: imem_req_addr, epoch: epoch, rdy: rdy});
      req_log.push_back(imem_req_addr);
    end
    if (redir) begin
      epoch++;
      m_fetch_pc = {rpc[31:2], 2'b00};
    end else if (fire) begin
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    m_started = 1'b1;
  endtask

  // Asynchronous reset: outputs must clear at once, without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_resp_valid = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr",  imem_req_addr, 32'd0);
    chk("rst_id_valid",  {31'b0, id_valid}, 32'd0);
    chk("rst_id_pc",     id_pc, 32'd0);
    chk("rst_id_inst",   id_inst, 32'd0);
    mem_q.delete(); mq.delete(); deq_log.delete(); req_log.delete();
    m_started = 1'b0; m_fetch_pc = 32'd0; last_rdy = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("sreset_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clk);
    cyc++;
    m_started = 1'b1;
  endtask

  task automatic knobs(input int rdy, input int idr, input int rdr, input int lmin, input int lmax);
    k_ready = rdy; k_idready = idr; k_redir = rdr; k_latmin = lmin; k_latmax = lmax;
  endtask

  initial begin
    int n;
    total = 0; bad = 0; cyc = 0; epoch = 0; force_redir = 1'b0; force_pc = 32'd0;
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_inst = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; id_ready = 1'b0;
    knobs(100, 100, 0, 1, 1);

    // Streaming with 1-cycle memory.
    do_reset();
    repeat (10) step();
    chk("t1_req_count", req_log.size(), 32'd10);
    chk("t1_req0", req_log[0], 32'h0);
    chk("t1_req1", req_log[1], 32'h4);
    chk("t1_req2", req_log[2], 32'h8);
    chk("t1_deq0", deq_log[0], 32'h0);
    chk("t1_deq1", deq_log[1], 32'h4);
    chk("t1_deq2", deq_log[2], 32'h8);
    // Redirect while a response and a request fire in the same cycle.
    force_redir = 1'b1; force_pc = 32'h0000_0200; deq_log.delete();
    repeat (10) step();
    chk("t4_first_new_pc", deq_log[0], 32'h200);

    // Decode stalled: credit stops requests at DEPTH.
    knobs(100, 0, 0, 1, 1);
    do_reset();
    repeat (20) step();
    chk("t2_req_count", req_log.size(), 32'd4);
    knobs(100, 100, 0, 1, 1);
    req_log.delete();
    repeat (20) step();
    chk("t2_deq0", deq_log[0], 32'h0);
    chk("t2_deq1", deq_log[1], 32'h4);
    chk("t2_deq2", deq_log[2], 32'h8);
    chk("t2_deq3", deq_log[3], 32'hC);
    chk("t2_resume", req_log[0], 32'h10);

    // 3-cycle memory, redirect with two requests in flight.
    knobs(100, 100, 0, 3, 3);
    do_reset();
    n = 0;
    while (mem_q.size() < 2 && n < 20) begin step(); n++; end
    chk("t3_inflight", mem_q.size(), 32'd2);
    force_redir = 1'b1; force_pc = 32'h0000_0103; deq_log.delete();
    repeat (30) step();
    chk("t3_seen", {31'b0, deq_log.size() != 0}, 32'd1);
    chk("t3_first_new_pc", deq_log[0], 32'h100);

    // Randomised traffic with redirects.
    knobs(70, 60, 20, 1, 5);
    do_reset();
    repeat (10000) step();

    // Reset mid-stream with requests outstanding.
    chk("t6_busy", {31'b0, (mem_q.size() + mq.size()) != 0}, 32'd1);
    knobs(100, 100, 0, 1, 1);
    do_reset();
    repeat (5) step();
    chk("t6_first_req", req_log[0], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
